// File: rtl/snake_pkg.sv
// Shared types for the snake step scheduler: direction encoding, the
// scheduler state enum and the opposite-direction helper.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t UP    = 2'd0;
  localparam dir_t DOWN  = 2'd1;
  localparam dir_t LEFT  = 2'd2;
  localparam dir_t RIGHT = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  // UP/DOWN and LEFT/RIGHT pairs differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_dir_queue.sv
// 2-deep direction FIFO. A push is dropped when it repeats or reverses the
// reference direction (tail entry if non-empty, else the current heading)
// or when the FIFO is full. Push and pop in the same cycle are both honoured.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   push, dir   candidate direction and its qualifier
//   pop         remove head (ignored when empty)
//   clear       flush all entries (wins over push/pop)
//   cur_dir     current heading, reference when empty
//   head, empty oldest entry and empty flag
module snake_dir_queue
  import snake_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  dir_t dir,
  input  logic pop,
  input  logic clear,
  input  dir_t cur_dir,
  output dir_t head,
  output logic empty
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  dir_t             slot0_q, slot0_d;
  dir_t             slot1_q, slot1_d;
  logic [CNT_W-1:0] count_q, count_d;

  dir_t ref_dir;
  logic full;
  logic accept;
  logic take;

  // Filtering and next-state for the two slots and the fill count.
  always_comb begin
    full    = (count_q == CNT_W'(DEPTH));
    ref_dir = cur_dir;
    if (count_q == CNT_W'(1)) ref_dir = slot0_q;
    else if (full)            ref_dir = slot1_q;

    accept = push && !full && (dir != ref_dir) && (dir != opposite(ref_dir));
    take   = pop && (count_q != '0);

    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;

    if (clear) begin
      count_d = '0;
    end else if (accept && take) begin
      // Only reachable with one entry: the new entry replaces the popped one.
      slot0_d = dir;
    end else if (take) begin
      slot0_d = slot1_q;
      count_d = count_q - CNT_W'(1);
    end else if (accept) begin
      if (count_q == '0) slot0_d = dir;
      else               slot1_d = dir;
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= RIGHT;
      slot1_q <= RIGHT;
      count_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head  = slot0_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/snake_step_scheduler.sv
// Snake movement sequencer: one step request per programmable period,
// buffered turns, no-reversal, pause, game-over and restart.
// Optional feature macro: SNAKE_SPEEDUP_EN (food shortens the step period).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   dir_in, dir_valid     direction command pulse
//   pause_toggle, restart button pulses
//   food_eaten, collision datapath event pulses
//   step_req, step_dir    step handshake to datapath (held until step_ack)
//   step_ack              datapath completed the step
//   paused, game_over     state flags
//   score                 foods eaten this game, saturating
module snake_step_scheduler
  import snake_pkg::*;
#(
  parameter int unsigned BASE_DIV   = 25_000_000,
  parameter int unsigned MIN_DIV    = 2_500_000,
  parameter int unsigned SPEED_STEP = 1_250_000,
  parameter int unsigned DIV_W      = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] dir_in,
  input  logic       dir_valid,
  input  logic       pause_toggle,
  input  logic       restart,
  input  logic       food_eaten,
  input  logic       collision,
  output logic       step_req,
  output logic [1:0] step_dir,
  input  logic       step_ack,
  output logic       paused,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int unsigned SCORE_W = 8;

`ifdef SNAKE_SPEEDUP_EN
  localparam bit SPEEDUP_EN = 1'b1;
`else
  localparam bit SPEEDUP_EN = 1'b0;
`endif

  localparam logic [DIV_W-1:0] DIV_BASE  = DIV_W'(BASE_DIV);
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DIV_DEC   = DIV_W'(SPEED_STEP);
  // Smallest period that can still absorb a full decrement; compared one bit
  // wider so the sum cannot wrap.
  localparam logic [DIV_W:0]   DIV_FLOOR = (DIV_W+1)'(MIN_DIV) + (DIV_W+1)'(SPEED_STEP);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   div_next_q, div_next_d;
  dir_t               cur_dir_q, cur_dir_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               coll_pend_q, coll_pend_d;
  logic               step_req_q, step_req_d;
  logic               paused_q, paused_d;
  logic               game_over_q, game_over_d;

  logic dq_push, dq_pop, dq_clear, dq_empty;
  dir_t dq_head;
  logic active;
  logic terminal;

  snake_dir_queue u_dir_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (dq_push),
    .dir     (dir_in),
    .pop     (dq_pop),
    .clear   (dq_clear),
    .cur_dir (cur_dir_q),
    .head    (dq_head),
    .empty   (dq_empty)
  );

  // Next-state, period counter, score/speed and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    div_next_d  = div_next_q;
    cur_dir_d   = cur_dir_q;
    score_d     = score_q;
    coll_pend_d = coll_pend_q;
    dq_pop      = 1'b0;
    dq_clear    = 1'b0;

    active   = (state_q == RUN) || (state_q == STEP);
    terminal = (state_q == RUN) && (cnt_q == div_q - DIV_W'(1));
    dq_push  = dir_valid && active;

    // div_next is the period for the next terminal; div is the live period.
    if (active && food_eaten) begin
      if (score_q != '1) score_d = score_q + SCORE_W'(1);
      if (SPEEDUP_EN) begin
        if ({1'b0, div_next_q} >= DIV_FLOOR) div_next_d = div_next_q - DIV_DEC;
        else                                 div_next_d = DIV_MIN;
      end
    end

    unique case (state_q)
      IDLE, OVER: begin
        if (restart) begin
          state_d     = RUN;
          cnt_d       = '0;
          div_d       = DIV_BASE;
          div_next_d  = DIV_BASE;
          cur_dir_d   = RIGHT;
          score_d     = '0;
          coll_pend_d = 1'b0;
          dq_clear    = 1'b1;
        end
      end
      RUN: begin
        if (collision) begin
          state_d = OVER;
        end else if (terminal) begin
          state_d = STEP;
          cnt_d   = '0;
          div_d   = div_next_d;
          dq_pop  = 1'b1;
          if (!dq_empty) cur_dir_d = dq_head;
        end else if (pause_toggle) begin
          state_d = PAUSE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      STEP: begin
        if (collision) coll_pend_d = 1'b1;
        if (step_ack) begin
          state_d     = (coll_pend_q || collision) ? OVER : RUN;
          coll_pend_d = 1'b0;
        end
      end
      PAUSE: begin
        if (pause_toggle) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    step_req_d  = (state_d == STEP);
    paused_d    = (state_d == PAUSE);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= DIV_BASE;
      div_next_q  <= DIV_BASE;
      cur_dir_q   <= RIGHT;
      score_q     <= '0;
      coll_pend_q <= 1'b0;
      step_req_q  <= 1'b0;
      paused_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      div_next_q  <= div_next_d;
      cur_dir_q   <= cur_dir_d;
      score_q     <= score_d;
      coll_pend_q <= coll_pend_d;
      step_req_q  <= step_req_d;
      paused_q    <= paused_d;
      game_over_q <= game_over_d;
    end
  end

  // cur_dir only changes on a terminal pop or restart, so it is stable in STEP.
  assign step_req  = step_req_q;
  assign step_dir  = cur_dir_q;
  assign paused    = paused_q;
  assign game_over = game_over_q;
  assign score     = score_q;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Bench for snake_step_scheduler: directed scenarios with hand-derived
// expectations plus a randomized run against a queue-based reference model.
module tb_snake_step_scheduler;

  localparam int BASE_DIV   = 8;
  localparam int MIN_DIV    = 4;
  localparam int SPEED_STEP = 3;
  localparam int DIV_W      = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dir_in = 2'd0;
  logic       dir_valid = 1'b0;
  logic       pause_toggle = 1'b0;
  logic       restart = 1'b0;
  logic       food_eaten = 1'b0;
  logic       collision = 1'b0;
  logic       step_ack = 1'b0;
  logic       step_req;
  logic [1:0] step_dir;
  logic       paused;
  logic       game_over;
  logic [7:0] score;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  snake_step_scheduler #(
    .BASE_DIV   (BASE_DIV),
    .MIN_DIV    (MIN_DIV),
    .SPEED_STEP (SPEED_STEP),
    .DIV_W      (DIV_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dir_in       (dir_in),
    .dir_valid    (dir_valid),
    .pause_toggle (pause_toggle),
    .restart      (restart),
    .food_eaten   (food_eaten),
    .collision    (collision),
    .step_req     (step_req),
    .step_dir     (step_dir),
    .step_ack     (step_ack),
    .paused       (paused),
    .game_over    (game_over),
    .score        (score)
  );

  // Reference model: game mode, period counter, pending turns as a queue.
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_PAUSE = 3, M_OVER = 4;
  int m_mode, m_cnt, m_div, m_divn, m_cur, m_score, m_ref;
  bit m_coll, m_live, m_take;
  int m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_cnt = 0; m_div = BASE_DIV; m_divn = BASE_DIV;
      m_cur = 3; m_score = 0; m_coll = 0; m_q.delete();
    end else begin
      m_live = (m_mode == M_RUN) || (m_mode == M_STEP);
      m_ref  = (m_q.size() > 0) ? m_q[$] : m_cur;
      m_take = m_live && dir_valid && (int'(dir_in) != m_ref) &&
               (int'(dir_in) != (m_ref ^ 1)) && (m_q.size() < 2);
      if (m_live && food_eaten) begin
        if (m_score < 255) m_score = m_score + 1;
`ifdef SNAKE_SPEEDUP_EN
        m_divn = (m_divn - SPEED_STEP < MIN_DIV) ? MIN_DIV : m_divn - SPEED_STEP;
`endif
      end
      case (m_mode)
        M_IDLE, M_OVER: if (restart) begin
          m_mode = M_RUN; m_cnt = 0; m_div = BASE_DIV; m_divn = BASE_DIV;
          m_cur = 3; m_score = 0; m_coll = 0; m_q.delete();
        end
        M_RUN: begin
          if (collision) m_mode = M_OVER;
          else if (m_cnt == m_div - 1) begin
            m_cnt = 0; m_div = m_divn; m_mode = M_STEP;
            if (m_q.size() > 0) m_cur = m_q.pop_front();
          end else if (pause_toggle) m_mode = M_PAUSE;
          else m_cnt = m_cnt + 1;
        end
        M_STEP: begin
          if (collision) m_coll = 1;
          if (step_ack) begin
            m_mode = m_coll ? M_OVER : M_RUN;
            m_coll = 0;
          end
        end
        M_PAUSE: if (pause_toggle) m_mode = M_RUN;
        default: ;
      endcase
      if (m_take) m_q.push_back(int'(dir_in));
    end
  end

  task automatic clear_pulses();
    dir_valid = 0; pause_toggle = 0; restart = 0; food_eaten = 0; collision = 0;
  endtask

  task automatic hard_reset();
    clear_pulses(); step_ack = 0; rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // Restart pulse at negedge k=0; returns at negedge k=1.
  task automatic start_game();
    restart = 1;
    @(negedge clk);
    restart = 0;
  endtask

  task automatic test_reset();
    clear_pulses(); step_ack = 0; rst_n = 0;
    #1;
    checks++; if (step_req !== 1'b0) begin errors++; $display("FAIL reset_step_req: got %0b want 0", step_req); end
    checks++; if (step_dir !== 2'd3) begin errors++; $display("FAIL reset_step_dir: got %0d want 3", step_dir); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused: got %0b want 0", paused); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %0b want 0", game_over); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    // IDLE must ignore pause and direction and never step.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++; if (step_req !== 1'b0 || paused !== 1'b0) begin
        errors++; $display("FAIL idle_quiet: step_req=%0b paused=%0b want 0 0", step_req, paused);
      end
      pause_toggle = (k % 3 == 0); dir_valid = 1; dir_in = 2'(k);
    end
    clear_pulses();
  endtask

  task automatic test_basic_period();
    bit exp;
    hard_reset(); step_ack = 1; start_game();
    for (int k = 1; k <= 40; k++) begin
      exp = (k % 9 == 0);
      checks++; if (step_req !== exp) begin errors++; $display("FAIL period_step_req k=%0d: got %0b want %0b", k, step_req, exp); end
      if (exp) begin
        checks++; if (step_dir !== 2'd3) begin errors++; $display("FAIL period_step_dir k=%0d: got %0d want 3", k, step_dir); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_double_turn();
    logic [1:0] want;
    hard_reset(); step_ack = 1; start_game();
    for (int k = 1; k <= 28; k++) begin
      clear_pulses();
      if (k == 2) begin dir_valid = 1; dir_in = 2'd0; end
      if (k == 3) begin dir_valid = 1; dir_in = 2'd2; end
      if (k == 4) begin dir_valid = 1; dir_in = 2'd1; end
      if (k == 9 || k == 18 || k == 27) begin
        want = (k == 9) ? 2'd0 : 2'd2;
        checks++; if (step_req !== 1'b1 || step_dir !== want) begin
          errors++; $display("FAIL double_turn k=%0d: step_req=%0b dir=%0d want 1 %0d", k, step_req, step_dir, want);
        end
      end
      @(negedge clk);
    end
    clear_pulses();
  endtask

  task automatic test_reversal();
    hard_reset(); step_ack = 1; start_game();
    for (int k = 1; k <= 9; k++) begin
      clear_pulses();
      if (k == 2) begin dir_valid = 1; dir_in = 2'd2; end
      if (k == 9) begin
        checks++; if (step_req !== 1'b1 || step_dir !== 2'd3) begin
          errors++; $display("FAIL reversal: step_req=%0b dir=%0d want 1 3", step_req, step_dir);
        end
      end
      @(negedge clk);
    end
    clear_pulses();
  endtask

  task automatic test_pause();
    hard_reset(); step_ack = 1; start_game();
    for (int k = 1; k <= 112; k++) begin
      clear_pulses();
      if (k == 4 || k == 105) pause_toggle = 1;
      if (k >= 5 && k <= 105) begin
        checks++; if (paused !== 1'b1 || step_req !== 1'b0) begin
          errors++; $display("FAIL pause_hold k=%0d: paused=%0b step_req=%0b want 1 0", k, paused, step_req);
        end
      end
      if (k >= 106 && k <= 110) begin
        checks++; if (paused !== 1'b0 || step_req !== 1'b0) begin
          errors++; $display("FAIL pause_resume k=%0d: paused=%0b step_req=%0b want 0 0", k, paused, step_req);
        end
      end
      if (k == 111) begin
        checks++; if (step_req !== 1'b1) begin errors++; $display("FAIL pause_step: got %0b want 1", step_req); end
      end
      @(negedge clk);
    end
    clear_pulses();
  endtask

  task automatic test_collision_step();
    hard_reset(); step_ack = 0; start_game();
    for (int k = 1; k <= 24; k++) begin
      clear_pulses(); step_ack = 0;
      if (k == 2) begin dir_valid = 1; dir_in = 2'd0; end
      if (k == 3) food_eaten = 1;
      if (k == 9) collision = 1;
      if (k == 13) step_ack = 1;
      if (k == 14) restart = 1;
      if (k >= 9 && k <= 13) begin
        checks++; if (step_req !== 1'b1 || step_dir !== 2'd0 || game_over !== 1'b0) begin
          errors++; $display("FAIL coll_hold k=%0d: step_req=%0b dir=%0d over=%0b want 1 0 0", k, step_req, step_dir, game_over);
        end
      end
      if (k == 14) begin
        checks++; if (step_req !== 1'b0 || game_over !== 1'b1 || score !== 8'd1) begin
          errors++; $display("FAIL coll_over: step_req=%0b over=%0b score=%0d want 0 1 1", step_req, game_over, score);
        end
      end
      if (k == 15) begin
        checks++; if (game_over !== 1'b0 || score !== 8'd0 || step_dir !== 2'd3) begin
          errors++; $display("FAIL restart: over=%0b score=%0d dir=%0d want 0 0 3", game_over, score, step_dir);
        end
      end
      if (k == 22 || k == 23) begin
        checks++; if (step_req !== (k == 23)) begin
          errors++; $display("FAIL restart_step k=%0d: got %0b want %0b", k, step_req, (k == 23));
        end
      end
      @(negedge clk);
    end
    clear_pulses(); step_ack = 0;
  endtask

  task automatic test_async_reset();
    hard_reset(); step_ack = 0; start_game();
    for (int k = 1; k < 10; k++) begin
      clear_pulses();
      if (k == 3) food_eaten = 1;
      @(negedge clk);
    end
    clear_pulses();
    checks++; if (step_req !== 1'b1 || score !== 8'd1) begin
      errors++; $display("FAIL pre_reset: step_req=%0b score=%0d want 1 1", step_req, score);
    end
    #2 rst_n = 0;
    #1;
    checks++; if (step_req !== 1'b0 || score !== 8'd0 || step_dir !== 2'd3) begin
      errors++; $display("FAIL async_reset: step_req=%0b score=%0d dir=%0d want 0 0 3", step_req, score, step_dir);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_speedup();
    bit exp;
    hard_reset(); step_ack = 1; start_game();
    for (int k = 1; k <= 36; k++) begin
      clear_pulses();
      if (k == 2 || k == 12) food_eaten = 1;
`ifdef SNAKE_SPEEDUP_EN
      exp = (k == 9) || (k == 15) || (k >= 20 && k % 5 == 0);
`else
      exp = (k % 9 == 0);
`endif
      checks++; if (step_req !== exp) begin errors++; $display("FAIL speed_step k=%0d: got %0b want %0b", k, step_req, exp); end
      if (k == 36) begin
        checks++; if (score !== 8'd2) begin errors++; $display("FAIL speed_score: got %0d want 2", score); end
      end
      @(negedge clk);
    end
    clear_pulses();
  endtask

  task automatic test_random();
    hard_reset();
    for (int k = 0; k < 3000; k++) begin
      checks++; if (step_req !== (m_mode == M_STEP) || step_dir !== 2'(m_cur)) begin
        errors++; $display("FAIL rand_step k=%0d: step_req=%0b dir=%0d want %0b %0d", k, step_req, step_dir, (m_mode == M_STEP), m_cur);
      end
      checks++; if (paused !== (m_mode == M_PAUSE) || game_over !== (m_mode == M_OVER)) begin
        errors++; $display("FAIL rand_flags k=%0d: paused=%0b over=%0b want %0b %0b", k, paused, game_over, (m_mode == M_PAUSE), (m_mode == M_OVER));
      end
      checks++; if (score !== 8'(m_score)) begin
        errors++; $display("FAIL rand_score k=%0d: got %0d want %0d", k, score, m_score);
      end
      restart      = ($urandom_range(0, 39) == 0);
      collision    = ($urandom_range(0, 199) == 0);
      pause_toggle = ($urandom_range(0, 39) == 0);
      food_eaten   = ($urandom_range(0, 15) == 0);
      dir_valid    = ($urandom_range(0, 2) == 0);
      dir_in       = 2'($urandom_range(0, 3));
      step_ack     = ($urandom_range(0, 1) == 0);
      @(negedge clk);
    end
    clear_pulses(); step_ack = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_period();
    test_double_turn();
    test_reversal();
    test_pause();
    test_collision_step();
    test_async_reset();
    test_speedup();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_step_scheduler.md
# snake_step_scheduler

Sequences snake movement for the game core. Produces one movement step per programmable period and buffers direction commands in a 2-deep queue, so quick double turns are not lost. Enforces no-reversal, pause, game-over and restart. Sits between the button decoder (direction/pause pulses) and the snake body datapath, which it drives over a step_req/step_ack handshake.

## Interface
- BASE_DIV, 25_000_000: clk cycles per step at game start.
- MIN_DIV, 2_500_000: lower bound on step period.
- SPEED_STEP, 1_250_000: period reduction per food eaten.
- DIV_W, 26: width of period counter and period register.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dir_in  in  2  requested direction (UP=0, DOWN=1, LEFT=2, RIGHT=3).
- dir_valid  in  1  one-cycle pulse qualifying dir_in.
- pause_toggle  in  1  one-cycle pulse toggling pause.
- restart  in  1  one-cycle pulse starting a new game.
- food_eaten  in  1  one-cycle pulse from the datapath.
- collision  in  1  one-cycle pulse from the datapath.
- step_req  out  1  step request to the datapath, held until acked.
- step_dir  out  2  direction for the requested step, stable while step_req=1.
- step_ack  in  1  datapath completed the step.
- paused  out  1  high in PAUSE.
- game_over  out  1  high in OVER.
- score  out  8  foods eaten this game, saturates at 255.

## Operation
- States: IDLE, RUN, STEP, PAUSE, OVER. Reset enters IDLE.
- IDLE/OVER + restart -> RUN. On entry: counter=0, queue cleared, cur_dir=RIGHT, div=BASE_DIV, score=0.
- RUN: counter increments each cycle. At counter==div-1: counter=0, pop queue head into cur_dir (if non-empty), go to STEP.
- STEP: step_req=1, step_dir=cur_dir. step_ack -> RUN. A step_ack outside STEP is ignored.
- RUN + pause_toggle -> PAUSE; PAUSE + pause_toggle -> RUN. The counter holds its value in PAUSE. pause_toggle is ignored in IDLE, STEP and OVER.
- Collision in RUN -> OVER. Collision in STEP is latched; on step_ack go to OVER, not RUN. Collision is ignored elsewhere.
- Direction queue:
  - Accepts in RUN and STEP only; dir_valid is discarded in IDLE, PAUSE and OVER.
  - Reference direction = queue tail if non-empty, else cur_dir.
  - Drop the entry if dir_in equals the reference, is its opposite, or the queue is full.
  - A push and a pop in the same cycle are both honoured.
- food_eaten (RUN/STEP only): score += 1 (saturating at 255). div is reduced per Configuration, taking effect at the next period.
- Simultaneous events in RUN, priority high to low: collision, period terminal, pause_toggle.

## Timing
- Reset values: step_req=0, step_dir=RIGHT, paused=0, game_over=0, score=0, counter=0, div=BASE_DIV, queue empty.
- All outputs are registered.
- step_req rises on the cycle after counter==div-1. Step period is therefore div cycles plus handshake cycles.
- step_req falls on the cycle after step_ack is sampled high. Zero-wait ack gives a 1-cycle STEP.
- paused and game_over follow the state with 1-cycle latency after the triggering pulse.
- rst_n low mid-handshake: step_req drops immediately (async) and all state returns to reset values.

## Configuration
- SNAKE_SPEEDUP_EN defined: each counted food_eaten sets div = max(div-SPEED_STEP, MIN_DIV); the subtraction must not underflow.
- Not defined: div is constant BASE_DIV and food_eaten only updates score.

## Structure
- Package snake_pkg holds:
  - direction constants UP/DOWN/LEFT/RIGHT and a 2-bit dir_t;
  - the state enum;
  - an opposite(dir) function.
- Sub-module snake_dir_queue is the 2-deep FIFO with reference-based filtering.
  - Ports: push, dir, pop, clear, head, empty.

## Test plan
- BASE_DIV=8, restart, ack held high: step_req pulses every 9 cycles with step_dir=RIGHT.
- In RUN facing RIGHT, dir_valid UP then LEFT in consecutive cycles: next two steps carry UP, then LEFT. A third pulse while the queue is full is dropped.
- Facing RIGHT, dir_valid LEFT: rejected, and the next step_dir stays RIGHT.
- pause_toggle at counter=3, wait 100 cycles, pause_toggle: paused=1 throughout, then the step fires 5 cycles after resume.
- Collision during STEP, ack 4 cycles later: step_req holds for 4 cycles, then game_over=1. restart then clears score and gives step_dir=RIGHT.
- With SNAKE_SPEEDUP_EN, BASE_DIV=8, MIN_DIV=4, SPEED_STEP=3, two food_eaten: div goes 8 -> 5 -> 4 and score=2.
